// File: rtl/enigma_pkg.sv
// Shared types and modular helper for the table-programmable rotor stage.
package enigma_pkg;
   localparam int ALPHA_DEF = 26;
   localparam int BASE_A    = 65;
   localparam int MOD_W     = 7;

   typedef enum logic [2:0] {
      UNCFG,
      CHECK,
      IDLE,
      CALC,
      OUT
   } rotor_state_e;

   // Operands must be < alpha (b may equal alpha); one conditional subtract folds the sum.
   function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                                input logic [MOD_W-1:0] b,
                                                input int alpha);
      logic [MOD_W-1:0] s;
      s = a + b;
      if (s >= MOD_W'(alpha)) s = s - MOD_W'(alpha);
      return s;
   endfunction
endpackage

// File: rtl/rotor_wiring_ram.sv
// Forward wiring table plus its inverse, written together so the inverse tracks every update.
// Combinational reads; addresses at or beyond ALPHA read as zero.
module rotor_wiring_ram #(
   parameter int ALPHA = 26,
   parameter int IDX_W = $clog2(ALPHA)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [IDX_W-1:0] wdata,
   input  logic [IDX_W-1:0] fwd_raddr,
   output logic [IDX_W-1:0] fwd_rdata,
   input  logic [IDX_W-1:0] inv_raddr,
   output logic [IDX_W-1:0] inv_rdata
);
   logic [IDX_W-1:0] fwd_mem [ALPHA];
   logic [IDX_W-1:0] inv_mem [ALPHA];

   always_ff @(posedge clk) begin
      if (we) begin
         fwd_mem[waddr] <= wdata;
         inv_mem[wdata] <= waddr;
      end
   end

   assign fwd_rdata = (int'(fwd_raddr) < ALPHA) ? fwd_mem[fwd_raddr] : '0;
   assign inv_rdata = (int'(inv_raddr) < ALPHA) ? inv_mem[inv_raddr] : '0;
endmodule

// File: rtl/enigma_rotor_stage.sv
// Rotor stage: programmable wiring with inverse, ring, notch carry; one symbol per 3 cycles,
// out_valid two cycles after acceptance, output held until out_ready (no input taken meanwhile).
module enigma_rotor_stage
   import enigma_pkg::*;
#(
   parameter int ALPHA = ALPHA_DEF,
   parameter int SYM_W = 8,
   parameter int BASE  = BASE_A,
   parameter int STEP  = 1,
   parameter int IDX_W = $clog2(ALPHA)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [SYM_W-1:0] cfg_data,
   input  logic             cfg_load,
   input  logic [IDX_W-1:0] cfg_pos,
   input  logic [IDX_W-1:0] cfg_ring,
   input  logic [IDX_W-1:0] cfg_notch,
   output logic             cfg_ok,
   input  logic             adv_in,
   output logic             carry_out,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SYM_W-1:0] in_sym,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SYM_W-1:0] out_sym,
   output logic             out_err
);
   rotor_state_e     state_q;
   logic             cfg_ok_q, in_ready_q, out_valid_q, out_err_q, carry_q;
   logic [SYM_W-1:0] out_sym_q, sym_q;
   logic             dir_q, err_q, bad_q;
   logic [IDX_W-1:0] pos_q, ring_q, notch_q, pcap_q, idx_q;

   logic             wr_ok, chk_bad, in_err_d;
   logic [IDX_W-1:0] wr_data, fwd_raddr, inv_raddr, fwd_rdata, inv_rdata;
   logic [IDX_W-1:0] calc_x, calc_e, calc_w, calc_y, pos_d;
   logic [SYM_W-1:0] out_sym_d;

   // Writes whose index or target falls outside the alphabet are dropped entirely.
   assign wr_ok   = cfg_we && (int'(cfg_addr) < ALPHA)
                    && (int'(cfg_data) >= BASE) && (int'(cfg_data) < BASE + ALPHA);
   assign wr_data = IDX_W'(cfg_data - SYM_W'(BASE));

   assign in_err_d = !((int'(in_sym) >= BASE) && (int'(in_sym) < BASE + ALPHA));

   rotor_wiring_ram #(.ALPHA(ALPHA), .IDX_W(IDX_W)) u_ram (
      .clk       (clk),
      .we        (wr_ok),
      .waddr     (cfg_addr),
      .wdata     (wr_data),
      .fwd_raddr (fwd_raddr),
      .fwd_rdata (fwd_rdata),
      .inv_raddr (inv_raddr),
      .inv_rdata (inv_rdata)
   );

   always_comb begin
      calc_x    = IDX_W'(sym_q - SYM_W'(BASE));
      calc_e    = IDX_W'(mod_add(mod_add(MOD_W'(calc_x), MOD_W'(pcap_q), ALPHA),
                                 MOD_W'(ALPHA) - MOD_W'(ring_q), ALPHA));
      // The check chains the two reads: inv is addressed by what fwd returns.
      fwd_raddr = (state_q == CHECK) ? idx_q : calc_e;
      inv_raddr = (state_q == CHECK) ? fwd_rdata : calc_e;
      chk_bad   = (int'(fwd_rdata) >= ALPHA) || (inv_rdata != idx_q);
      calc_w    = dir_q ? inv_rdata : fwd_rdata;
      calc_y    = IDX_W'(mod_add(mod_add(MOD_W'(calc_w), MOD_W'(ring_q), ALPHA),
                                 MOD_W'(ALPHA) - MOD_W'(pcap_q), ALPHA));
      out_sym_d = err_q ? sym_q : SYM_W'(calc_y) + SYM_W'(BASE);
      pos_d     = IDX_W'(mod_add(MOD_W'(pos_q), MOD_W'(STEP), ALPHA));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= UNCFG;
         cfg_ok_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_err_q   <= 1'b0;
         carry_q     <= 1'b0;
         pos_q       <= '0;
         ring_q      <= '0;
         notch_q     <= '0;
         pcap_q      <= '0;
         idx_q       <= '0;
         sym_q       <= '0;
         dir_q       <= 1'b0;
         err_q       <= 1'b0;
         bad_q       <= 1'b0;
      end else begin
         carry_q <= 1'b0;
         if (adv_in && (state_q inside {IDLE, CALC, OUT})) begin
            pos_q   <= pos_d;
            carry_q <= (pos_q == notch_q);
         end
         if (wr_ok) begin
            state_q     <= UNCFG;
            cfg_ok_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
         end else if (cfg_load) begin
            state_q     <= CHECK;
            pos_q       <= cfg_pos;
            ring_q      <= cfg_ring;
            notch_q     <= cfg_notch;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            cfg_ok_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            case (state_q)
               UNCFG: ;
               CHECK: begin
                  if (int'(idx_q) == ALPHA - 1) begin
                     if (bad_q || chk_bad) begin
                        state_q <= UNCFG;
                     end else begin
                        state_q    <= IDLE;
                        cfg_ok_q   <= 1'b1;
                        in_ready_q <= 1'b1;
                     end
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     bad_q <= bad_q | chk_bad;
                  end
               end
               IDLE: begin
                  if (in_valid) begin
                     sym_q      <= in_sym;
                     dir_q      <= in_dir;
                     err_q      <= in_err_d;
                     pcap_q     <= pos_q;
                     in_ready_q <= 1'b0;
                     state_q    <= CALC;
                  end
               end
               CALC: begin
                  out_sym_q   <= out_sym_d;
                  out_err_q   <= err_q;
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end
               OUT: begin
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
               default: state_q <= UNCFG;
            endcase
         end
      end
   end

   assign cfg_ok    = cfg_ok_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_err   = out_err_q;
   assign carry_out = carry_q;
endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Bench for enigma_rotor_stage: vector table, corner sequences and a randomized reference-model run.
module tb_enigma_rotor_stage;
   localparam int A = 26;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, cfg_we, cfg_load, adv_in, in_valid, in_dir, out_ready;
   logic [4:0] cfg_addr, cfg_pos, cfg_ring, cfg_notch;
   logic [7:0] cfg_data, in_sym, out_sym;
   logic       cfg_ok, carry_out, in_ready, out_valid, out_err;

   int checks = 0, failures = 0;
   int fwd_m[A], inv_m[A];
   int mpos, mring, mnotch;
   string wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

   typedef struct {
      int sym; int dir; int pos; int ring; int exp_sym; int exp_err;
   } vec_t;
   vec_t vecs[9];

   enigma_rotor_stage #(.ALPHA(26), .SYM_W(8), .BASE(65), .STEP(1)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_load(cfg_load), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring), .cfg_notch(cfg_notch),
      .cfg_ok(cfg_ok), .adv_in(adv_in), .carry_out(carry_out), .in_valid(in_valid),
      .in_ready(in_ready), .in_sym(in_sym), .in_dir(in_dir), .out_valid(out_valid),
      .out_ready(out_ready), .out_sym(out_sym), .out_err(out_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic int ref_err(input int sym);
      return (sym < 65 || sym >= 65 + A) ? 1 : 0;
   endfunction

   function automatic int ref_sym(input int sym, input int dir, input int p, input int r);
      int e, w;
      if (ref_err(sym) == 1) return sym;
      e = ((sym - 65) + p - r + 2 * A) % A;
      w = (dir != 0) ? inv_m[e] : fwd_m[e];
      return ((w - p + r + 2 * A) % A) + 65;
   endfunction

   task automatic load_table;
      for (int i = 0; i < A; i++) begin
         cfg_we   = 1'b1;
         cfg_addr = 5'(i);
         cfg_data = 8'(wiring[i]);
         fwd_m[i] = int'(wiring[i]) - 65;
         tick;
      end
      cfg_we = 1'b0;
      for (int i = 0; i < A; i++) inv_m[fwd_m[i]] = i;
   endtask

   task automatic configure(input int p, input int r, input int nt, output int cyc);
      cfg_load  = 1'b1;
      cfg_pos   = 5'(p);
      cfg_ring  = 5'(r);
      cfg_notch = 5'(nt);
      tick;
      cfg_load = 1'b0;
      cyc = 0;
      while (!cfg_ok && cyc < 40) begin
         tick;
         cyc++;
      end
      mpos = p; mring = r; mnotch = nt;
   endtask

   task automatic do_xlate(input string nm, input int sym, input int dir, input int adv,
                           input int exp_sym, input int exp_err);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick;
         n++;
      end
      if (!in_ready) begin
         chk({nm, "_ready_timeout"}, 0, 1);
         return;
      end
      in_valid  = 1'b1;
      in_sym    = 8'(sym);
      in_dir    = dir[0];
      adv_in    = adv[0];
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      adv_in   = 1'b0;
      chk({nm, "_carry"}, int'(carry_out), (adv != 0 && mpos == mnotch) ? 1 : 0);
      if (adv != 0) mpos = (mpos + 1) % A;
      chk({nm, "_early_vld"}, int'(out_valid), 0);
      tick;
      chk({nm, "_vld"}, int'(out_valid), 1);
      chk({nm, "_sym"}, int'(out_sym), exp_sym);
      chk({nm, "_err"}, int'(out_err), exp_err);
      tick;
   endtask

   initial begin
      int cyc, s, d, a, seen;
      reset = 1'b1; cfg_we = 1'b0; cfg_load = 1'b0; adv_in = 1'b0; in_valid = 1'b0;
      in_dir = 1'b0; out_ready = 1'b0; cfg_addr = '0; cfg_pos = '0; cfg_ring = '0;
      cfg_notch = '0; cfg_data = '0; in_sym = '0;
      mpos = 0; mring = 0; mnotch = 0;
      vecs[0] = '{65, 0, 0, 0, 69, 0};
      vecs[1] = '{69, 1, 0, 0, 65, 0};
      vecs[2] = '{66, 0, 0, 0, 75, 0};
      vecs[3] = '{90, 0, 0, 0, 74, 0};
      vecs[4] = '{35, 0, 0, 0, 35, 1};
      vecs[5] = '{91, 1, 0, 0, 91, 1};
      vecs[6] = '{64, 0, 0, 0, 64, 1};
      vecs[7] = '{65, 0, 1, 0, 74, 0};
      vecs[8] = '{65, 0, 0, 1, 75, 0};

      tick; tick;
      chk("rst_cfg_ok", int'(cfg_ok), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sym", int'(out_sym), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_carry", int'(carry_out), 0);
      reset = 1'b0;
      tick;

      load_table;
      configure(0, 0, 16, cyc);
      chk("cfg_latency", cyc, 26);
      chk("cfg_ok_up", int'(cfg_ok), 1);
      chk("cfg_in_ready", int'(in_ready), 1);

      // A second load mid-scan restarts the full-length check.
      cfg_load = 1'b1; tick; cfg_load = 1'b0;
      for (int i = 0; i < 10; i++) tick;
      chk("restart_midscan_ok", int'(cfg_ok), 0);
      configure(0, 0, 16, cyc);
      chk("restart_latency", cyc, 26);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].pos != mpos || vecs[i].ring != mring) begin
            configure(vecs[i].pos, vecs[i].ring, 16, cyc);
            chk($sformatf("vec%0d_cfg", i), cyc, 26);
         end
         do_xlate($sformatf("vec%0d", i), vecs[i].sym, vecs[i].dir, 0,
                  vecs[i].exp_sym, vecs[i].exp_err);
      end

      // Notch carry and wrap-around stepping.
      configure(16, 0, 16, cyc);
      adv_in = 1'b1; tick; adv_in = 1'b0;
      chk("notch_carry", int'(carry_out), 1);
      tick;
      chk("notch_carry_pulse_end", int'(carry_out), 0);
      do_xlate("pos17", 65, 0, 0, ref_sym(65, 0, 17, 0), 0);
      configure(25, 0, 16, cyc);
      adv_in = 1'b1; tick; adv_in = 1'b0;
      chk("wrap_no_carry", int'(carry_out), 0);
      do_xlate("wrap_pos0", 65, 0, 0, 69, 0);

      // Held output under backpressure with an out-of-range symbol.
      in_valid = 1'b1; in_sym = 8'd35; in_dir = 1'b0; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      tick;
      chk("hold_vld", int'(out_valid), 1);
      chk("hold_err", int'(out_err), 1);
      chk("hold_sym", int'(out_sym), 35);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (!out_valid || out_sym != 8'd35 || in_ready) seen = 1;
      end
      chk("hold_stable_5cyc", seen, 0);
      out_ready = 1'b1;
      tick;
      chk("hold_release_vld", int'(out_valid), 0);
      chk("hold_release_rdy", int'(in_ready), 1);

      // Randomized traffic against the reference model.
      for (int b = 0; b < 3; b++) begin
         configure(int'($urandom % A), int'($urandom % A), int'($urandom % A), cyc);
         chk($sformatf("rnd%0d_cfg", b), cyc, 26);
         for (int k = 0; k < 15; k++) begin
            s = int'($urandom_range(60, 95));
            d = int'($urandom % 2);
            a = ($urandom % 4 == 0) ? 1 : 0;
            do_xlate($sformatf("rnd%0d_%0d", b, k), s, d, a,
                     ref_sym(s, d, mpos, mring), ref_err(s));
         end
      end

      // A duplicate wiring entry must fail the permutation check.
      cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 8'd69;
      tick;
      cfg_we = 1'b0;
      chk("dup_write_drops_ok", int'(cfg_ok), 0);
      cfg_load = 1'b1; tick; cfg_load = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (in_ready || cfg_ok) seen = 1;
      end
      chk("dup_never_ready", seen, 0);
      chk("dup_cfg_ok", int'(cfg_ok), 0);

      // Reset while a symbol is in flight.
      load_table;
      configure(0, 0, 16, cyc);
      chk("pre_rst_cfg", int'(cfg_ok), 1);
      in_valid = 1'b1; in_sym = 8'd65; in_dir = 1'b0; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("midrst_cfg_ok", int'(cfg_ok), 0);
      seen = (out_valid) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (out_valid || in_ready) seen = 1;
      end
      chk("midrst_no_output", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
